// File: rtl/decode_operand_stage_if.sv
// Instruction handshake bundle around the decode/operand stage: FD fields in, resolved DE operands out.
// The stage takes the slave view; the surrounding pipeline (or bench) takes the master view.
interface decode_operand_stage_if #(
  parameter int REG_W     = 8,
  parameter int REG_PTR_W = 4
);
  logic                 FD_valid;
  logic                 FD_ready;
  logic [REG_PTR_W-1:0] FD_insn_src_0;
  logic [REG_PTR_W-1:0] FD_insn_src_1;
  logic [REG_PTR_W-1:0] FD_insn_src_2;
  logic [2:0]           FD_insn_uses_src;
  logic [REG_PTR_W-1:0] FD_insn_dst;
  logic                 FD_insn_wr_dst;

  logic                 DE_valid;
  logic                 DE_ready;
  logic [REG_W-1:0]     DE_src_0_data;
  logic [REG_W-1:0]     DE_src_1_data;
  logic [REG_W-1:0]     DE_src_2_data;
  logic [REG_PTR_W-1:0] DE_insn_dst;
  logic                 DE_insn_wr_dst;

  modport slave (
    input  FD_valid, FD_insn_src_0, FD_insn_src_1, FD_insn_src_2,
    input  FD_insn_uses_src, FD_insn_dst, FD_insn_wr_dst, DE_ready,
    output FD_ready, DE_valid, DE_src_0_data, DE_src_1_data, DE_src_2_data,
    output DE_insn_dst, DE_insn_wr_dst
  );

  modport master (
    output FD_valid, FD_insn_src_0, FD_insn_src_1, FD_insn_src_2,
    output FD_insn_uses_src, FD_insn_dst, FD_insn_wr_dst, DE_ready,
    input  FD_ready, DE_valid, DE_src_0_data, DE_src_1_data, DE_src_2_data,
    input  DE_insn_dst, DE_insn_wr_dst
  );
endinterface

// File: rtl/decode_operand_stage.sv
// Operand fetch with writeback bypass and pending-write scoreboard; FD->DE latency 1 cycle.
// Stalls FD (FD_ready=0) on RAW/WAW hazard, flush, or DE held by execute backpressure.
module decode_operand_stage #(
  parameter int REG_W     = 8,
  parameter int REG_PTR_W = 4,
  parameter int REG_COUNT = 16
) (
  input  logic                 clk,
  input  logic                 reset_DE_n,
  decode_operand_stage_if.slave bus,
  input  logic [REG_W-1:0]     D_src_0_data,
  input  logic [REG_W-1:0]     D_src_1_data,
  input  logic [REG_W-1:0]     D_src_2_data,
  input  logic [REG_PTR_W-1:0] MW_insn_dst,
  input  logic                 MW_insn_wr,
  input  logic [REG_W-1:0]     W_result,
  input  logic                 init_R0,
  input  logic [REG_W-1:0]     init_R0_data,
  input  logic                 flush
);
  localparam int NSRC = 3;

  typedef struct packed {
    logic [NSRC-1:0][REG_W-1:0] src;
    logic [REG_PTR_W-1:0]       dst;
    logic                       wr_dst;
  } de_t;

  de_t                           de_q, de_d;
  logic                          de_valid_q, de_valid_d;
  logic [REG_COUNT-1:0]          pending_q, pending_d;

  logic [NSRC-1:0][REG_PTR_W-1:0] src_idx;
  logic [NSRC-1:0][REG_W-1:0]     rf_dat;
  logic [NSRC-1:0][REG_W-1:0]     byp_dat;
  logic [REG_COUNT-1:0]           clr;
  logic [REG_COUNT-1:0]           flush_kill;
  logic                           hazard;
  logic                           fd_ready;
  logic                           accept;

  assign src_idx = {bus.FD_insn_src_2, bus.FD_insn_src_1, bus.FD_insn_src_0};
  assign rf_dat  = {D_src_2_data, D_src_1_data, D_src_0_data};

  // R0 initialisation outranks the writeback bypass, which outranks the register file.
  always_comb begin
    for (int k = 0; k < NSRC; k++) begin
      byp_dat[k] = rf_dat[k];
      if (init_R0 && (src_idx[k] == '0)) begin
        byp_dat[k] = init_R0_data;
      end else if (MW_insn_wr && (MW_insn_dst == src_idx[k])) begin
        byp_dat[k] = W_result;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      clr[i]        = MW_insn_wr && (MW_insn_dst == REG_PTR_W'(i));
      flush_kill[i] = flush && de_valid_q && de_q.wr_dst && (de_q.dst == REG_PTR_W'(i));
    end
  end

  // A write landing this cycle resolves the hazard because its value is bypassed.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (bus.FD_insn_uses_src[k] && pending_q[src_idx[k]] && !clr[src_idx[k]]) begin
        hazard = 1'b1;
      end
    end
    if (bus.FD_insn_wr_dst && pending_q[bus.FD_insn_dst] && !clr[bus.FD_insn_dst]) begin
      hazard = 1'b1;
    end
  end

  assign fd_ready = !hazard && (!de_valid_q || bus.DE_ready) && !flush;
  assign accept   = bus.FD_valid && fd_ready;

  always_comb begin
    de_d       = de_q;
    de_valid_d = de_valid_q;
    if (accept) begin
      de_d.src    = byp_dat;
      de_d.dst    = bus.FD_insn_dst;
      de_d.wr_dst = bus.FD_insn_wr_dst;
      de_valid_d  = 1'b1;
    end else if (bus.DE_ready || flush) begin
      de_valid_d  = 1'b0;
    end
  end

  // Set after clear so a same-cycle set of the same index wins.
  always_comb begin
    pending_d = pending_q & ~(clr | flush_kill);
    if (accept && bus.FD_insn_wr_dst) begin
      pending_d[bus.FD_insn_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_DE_n) begin
    if (!reset_DE_n) begin
      de_q       <= '0;
      de_valid_q <= 1'b0;
      pending_q  <= '0;
    end else begin
      de_q       <= de_d;
      de_valid_q <= de_valid_d;
      pending_q  <= pending_d;
    end
  end

  assign bus.FD_ready       = fd_ready;
  assign bus.DE_valid       = de_valid_q;
  assign bus.DE_src_0_data  = de_q.src[0];
  assign bus.DE_src_1_data  = de_q.src[1];
  assign bus.DE_src_2_data  = de_q.src[2];
  assign bus.DE_insn_dst    = de_q.dst;
  assign bus.DE_insn_wr_dst = de_q.wr_dst;
endmodule
